// File: rtl/thwomp_pkg.sv
// Shared definitions for the Thwomp drop controller.
//   state_e       : controller state encoding (also exported on o_state for debug)
//   THWOMP_WIDTH  : sprite width in pixels
//   THWOMP_HEIGHT : sprite height in pixels
//   FLOOR_DEFAULT : y of the top of the floor blocks in pixels
package thwomp_pkg;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StLoad  = 3'd1,
    StHover = 3'd2,
    StFall  = 3'd3,
    StLand  = 3'd4
  } state_e;

  localparam int unsigned THWOMP_WIDTH  = 24;
  localparam int unsigned THWOMP_HEIGHT = 32;
  localparam int unsigned FLOOR_DEFAULT = 450;

endpackage

// File: rtl/thwomp_drop_ctrl_if.sv
// Read port of the PRNG's Thwomp-coordinate FIFO.
//   fifo_empty : FIFO empty flag (FIFOempty_full[1])
//   prng_x     : bounded random x (prng_xThwomp), valid the cycle after rden
//   rden       : read enable (thwompNewLocation), single-cycle pulse
// master = drop controller (consumer), slave = PRNG FIFO (producer).
interface thwomp_drop_ctrl_if;

  logic       fifo_empty;
  logic [9:0] prng_x;
  logic       rden;

  modport master (
    input  fifo_empty,
    input  prng_x,
    output rden
  );

  modport slave (
    output fifo_empty,
    output prng_x,
    input  rden
  );

endinterface

// File: rtl/thwomp_drop_ctrl_frame_counter.sv
// 8-bit frame counter shared by the hover and land phases.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   tick_i : count enable (already qualified with frame tick, enable and state)
//   clr_i  : synchronous clear
//   last_i : terminal count (number of frames - 1)
//   done_o : high on the tick that reaches last_i; the counter wraps to 0 on it
module thwomp_drop_ctrl_frame_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       clr_i,
  input  logic [7:0] last_i,
  output logic       done_o
);

  logic [7:0] count_q, count_d;

  assign done_o = tick_i && (count_q == last_i);

  always_comb begin
    count_d = count_q;
    if (clr_i || done_o) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/thwomp_drop_ctrl.sv
// Thwomp motion controller: pops a random x from the PRNG FIFO, hovers at Y_START,
// falls under gravity until it rests on the floor, waits, then repeats.
//   clkFIFOread  : 25 MHz pixel / FIFO-read clock
//   rst          : asynchronous active-high reset
//   i_frame_tick : one-cycle pulse per video frame
//   i_enable     : game running; 0 freezes all motion and suppresses FIFO reads
//   fifo         : FIFO read port (empty flag, random x, read enable)
//   o_x, o_y     : sprite position (o_y is the top edge)
//   o_active     : sprite visible / collidable
//   o_landed     : one-cycle pulse on floor impact
//   o_state      : current state, for debug
module thwomp_drop_ctrl
  import thwomp_pkg::*;
#(
  parameter int unsigned FLOOR         = FLOOR_DEFAULT,
  parameter int unsigned THWOMP_HEIGHT = thwomp_pkg::THWOMP_HEIGHT,
  parameter int unsigned Y_START       = 0,
  parameter int unsigned HOVER_FRAMES  = 60,  // 1..255
  parameter int unsigned LAND_FRAMES   = 30,  // 1..255
  parameter int unsigned GRAVITY       = 1,
  parameter int unsigned MAX_VEL       = 8    // <= 15
) (
  input  logic                       clkFIFOread,
  input  logic                       rst,
  input  logic                       i_frame_tick,
  input  logic                       i_enable,
  thwomp_drop_ctrl_if.master         fifo,
  output logic [9:0]                 o_x,
  output logic [9:0]                 o_y,
  output logic                       o_active,
  output logic                       o_landed,
  output logic [2:0]                 o_state
);

  localparam logic [9:0] YStart    = 10'(Y_START);
  localparam logic [9:0] LandY     = 10'(FLOOR - THWOMP_HEIGHT);
  localparam logic [3:0] Gravity   = 4'(GRAVITY);
  localparam logic [3:0] MaxVel    = 4'(MAX_VEL);
  localparam logic [7:0] HoverLast = 8'(HOVER_FRAMES - 1);
  localparam logic [7:0] LandLast  = 8'(LAND_FRAMES - 1);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  vel_q, vel_d;
  logic        active_q, active_d;
  logic        landed_q, landed_d;
  logic        rden;

  logic        cnt_tick, cnt_clr, cnt_done;
  logic [7:0]  cnt_last;

  logic [4:0]  vel_sum;
  logic [3:0]  vel_n;
  logic [10:0] y_n;

  // Gravity step; y_n is one bit wider so the floor compare cannot wrap.
  always_comb begin
    vel_sum = {1'b0, vel_q} + {1'b0, Gravity};
    vel_n   = (vel_sum > {1'b0, MaxVel}) ? MaxVel : vel_sum[3:0];
    y_n     = {1'b0, y_q} + {7'd0, vel_n};
  end

  assign cnt_tick = i_enable && i_frame_tick && (state_q == StHover || state_q == StLand);
  assign cnt_clr  = i_enable && (state_q == StLoad);
  assign cnt_last = (state_q == StLand) ? LandLast : HoverLast;

  thwomp_drop_ctrl_frame_counter u_frame_counter (
    .clk_i  (clkFIFOread),
    .rst_i  (rst),
    .tick_i (cnt_tick),
    .clr_i  (cnt_clr),
    .last_i (cnt_last),
    .done_o (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    vel_d    = vel_q;
    active_d = active_q;
    landed_d = 1'b0;  // self-clearing even while frozen so the pulse stays one cycle
    rden     = 1'b0;
    if (i_enable) begin
      case (state_q)
        StFetch: begin
          // Combinational so the FIFO data lands in the LOAD cycle.
          if (!fifo.fifo_empty) begin
            rden    = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad: begin
          x_d      = fifo.prng_x;
          y_d      = YStart;
          vel_d    = '0;
          active_d = 1'b1;
          state_d  = StHover;
        end
        StHover: begin
          if (cnt_done) state_d = StFall;
        end
        StFall: begin
          if (i_frame_tick) begin
            if (y_n >= {1'b0, LandY}) begin
              y_d      = LandY;
              vel_d    = '0;
              landed_d = 1'b1;
              state_d  = StLand;
            end else begin
              y_d   = y_n[9:0];
              vel_d = vel_n;
            end
          end
        end
        StLand: begin
          if (cnt_done) begin
            active_d = 1'b0;
            state_d  = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clkFIFOread or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      x_q      <= '0;
      y_q      <= YStart;
      vel_q    <= '0;
      active_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vel_q    <= vel_d;
      active_q <= active_d;
      landed_q <= landed_d;
    end
  end

  // Reset also masks the read strobe: the state is FETCH while rst is high.
  assign fifo.rden = rden && !rst;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_active  = active_q;
  assign o_landed  = landed_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_thwomp_drop_ctrl.sv
// Self-checking bench for thwomp_drop_ctrl: reset, fetch handshake, hover count,
// gravity fall with floor clamp, land wait, enable freeze and asynchronous reset mid-fall.
module tb_thwomp_drop_ctrl;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HOVER = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_LAND  = 3'd4;
  localparam int HOVER  = 60;
  localparam int LAND   = 30;
  localparam int LAND_Y = 450 - 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       enable;
  logic [9:0] o_x, o_y;
  logic       o_active, o_landed;
  logic [2:0] o_state;

  thwomp_drop_ctrl_if fifo_if ();

  thwomp_drop_ctrl dut (
    .clkFIFOread  (clk),
    .rst          (rst),
    .i_frame_tick (frame_tick),
    .i_enable     (enable),
    .fifo         (fifo_if),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_active     (o_active),
    .o_landed     (o_landed),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int xq[$];
  int yq[$];
  int m_y, m_v;

  int   rden_pulses   = 0;
  int   rden_bad      = 0;
  int   landed_pulses = 0;
  logic rden_prev     = 1'b0;

  // Protocol monitor, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #3;
    if (fifo_if.rden === 1'b1) begin
      rden_pulses++;
      if (fifo_if.fifo_empty !== 1'b0 || rden_prev === 1'b1) rden_bad++;
    end
    if (o_landed === 1'b1) landed_pulses++;
    rden_prev = fifo_if.rden;
  end

  task automatic send_tick();
    repeat (9) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int exp;
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b0;
    fifo_if.fifo_empty = 1'b0; fifo_if.prng_x = 10'd300;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (o_state !== S_FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", o_state, S_FETCH); end
    n_checks++; if (o_x !== 10'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", o_x); end
    n_checks++; if (o_y !== 10'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", o_y); end
    n_checks++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b want 0", o_active); end
    n_checks++; if (o_landed !== 1'b0) begin n_fail++; $display("FAIL reset_landed: got %0b want 0", o_landed); end
    n_checks++; if (fifo_if.rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %0b want 0", fifo_if.rden); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_if.rden !== 1'b1) begin n_fail++; $display("FAIL release_rden: got %0b want 1", fifo_if.rden); end
    xq.push_back(300);
    @(negedge clk);
    fifo_if.fifo_empty = 1'b1;
    #1;
    n_checks++; if (fifo_if.rden !== 1'b0) begin n_fail++; $display("FAIL release_rden_single: got %0b want 0", fifo_if.rden); end
    n_checks++; if (o_state !== S_LOAD) begin n_fail++; $display("FAIL release_load: got %0d want %0d", o_state, S_LOAD); end
    @(negedge clk);
    #1;
    exp = xq.pop_front();
    n_checks++; if (o_state !== S_HOVER) begin n_fail++; $display("FAIL release_hover: got %0d want %0d", o_state, S_HOVER); end
    n_checks++; if (o_x !== 10'(exp)) begin n_fail++; $display("FAIL release_x: got %0d want %0d", o_x, exp); end
    n_checks++; if (o_y !== 10'd0) begin n_fail++; $display("FAIL release_y: got %0d want 0", o_y); end
    n_checks++; if (o_active !== 1'b1) begin n_fail++; $display("FAIL release_active: got %0b want 1", o_active); end
  endtask

  task automatic test_fetch(input int x, input int empty_cycles, input int frozen_cycles);
    int lr, bad, exp;
    lr = rden_pulses; bad = 0;
    fifo_if.fifo_empty = 1'b1;
    for (int i = 0; i < empty_cycles; i++) begin
      @(negedge clk); #1;
      if (fifo_if.rden !== 1'b0 || o_active !== 1'b0 || o_state !== S_FETCH) bad++;
    end
    enable = 1'b0;
    fifo_if.fifo_empty = 1'b0;
    for (int i = 0; i < frozen_cycles; i++) begin
      @(negedge clk); #1;
      if (fifo_if.rden !== 1'b0 || o_state !== S_FETCH) bad++;
    end
    n_checks++;
    if (bad != 0 || rden_pulses != lr) begin
      n_fail++;
      $display("FAIL fetch_wait: got %0d bad cycles / %0d pulses, want 0 / 0", bad, rden_pulses - lr);
    end
    @(negedge clk);
    enable = 1'b1; fifo_if.prng_x = 10'(x); fifo_if.fifo_empty = 1'b0;
    #1;
    n_checks++; if (fifo_if.rden !== 1'b1) begin n_fail++; $display("FAIL fetch_rden: got %0b want 1", fifo_if.rden); end
    xq.push_back(x);
    @(negedge clk);
    fifo_if.fifo_empty = 1'b1;
    #1;
    n_checks++; if (o_state !== S_LOAD) begin n_fail++; $display("FAIL fetch_load: got %0d want %0d", o_state, S_LOAD); end
    @(negedge clk); #1;
    exp = xq.pop_front();
    n_checks++; if (o_state !== S_HOVER) begin n_fail++; $display("FAIL fetch_hover: got %0d want %0d", o_state, S_HOVER); end
    n_checks++; if (o_x !== 10'(exp)) begin n_fail++; $display("FAIL fetch_x: got %0d want %0d", o_x, exp); end
    n_checks++; if (o_y !== 10'd0) begin n_fail++; $display("FAIL fetch_y: got %0d want 0", o_y); end
    n_checks++; if (o_active !== 1'b1) begin n_fail++; $display("FAIL fetch_active: got %0b want 1", o_active); end
  endtask

  task automatic test_hover();
    for (int i = 1; i <= HOVER; i++) begin
      send_tick();
      if (i == HOVER - 1) begin
        n_checks++; if (o_state !== S_HOVER) begin n_fail++; $display("FAIL hover_hold: got %0d want %0d", o_state, S_HOVER); end
        n_checks++; if (o_y !== 10'd0) begin n_fail++; $display("FAIL hover_y: got %0d want 0", o_y); end
      end
    end
    n_checks++; if (o_state !== S_FALL) begin n_fail++; $display("FAIL hover_to_fall: got %0d want %0d", o_state, S_FALL); end
    m_y = 0; m_v = 0;
  endtask

  task automatic test_freeze();
    int lr;
    lr = rden_pulses;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_tick();
      n_checks++; if (o_y !== 10'(m_y)) begin n_fail++; $display("FAIL freeze_y: got %0d want %0d", o_y, m_y); end
      n_checks++; if (o_state !== S_FALL) begin n_fail++; $display("FAIL freeze_state: got %0d want %0d", o_state, S_FALL); end
    end
    n_checks++; if (rden_pulses != lr) begin n_fail++; $display("FAIL freeze_rden: got %0d pulses want 0", rden_pulses - lr); end
    enable = 1'b1;
  endtask

  task automatic test_fall(input int freeze_at, input int stop_y);
    int  k, exp, lp;
    bit  landed;
    k = 0; landed = 1'b0;
    while (!landed && k < 200) begin
      if (stop_y != 0 && m_y == stop_y) return;
      if (k == freeze_at) test_freeze();
      m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
      if (m_y + m_v >= LAND_Y) begin m_y = LAND_Y; m_v = 0; landed = 1'b1; end
      else m_y = m_y + m_v;
      yq.push_back(m_y);
      lp = landed_pulses;
      send_tick();
      k++;
      exp = yq.pop_front();
      n_checks++; if (o_y !== 10'(exp)) begin n_fail++; $display("FAIL fall_y[%0d]: got %0d want %0d", k, o_y, exp); end
      if (k == 1) begin
        n_checks++; if (o_y !== 10'd1) begin n_fail++; $display("FAIL fall_first: got %0d want 1", o_y); end
      end
      if (k == 8) begin
        n_checks++; if (o_y !== 10'd36) begin n_fail++; $display("FAIL fall_cap: got %0d want 36", o_y); end
      end
      if (landed) begin
        n_checks++; if (o_y !== 10'd418) begin n_fail++; $display("FAIL land_clamp: got %0d want 418", o_y); end
        n_checks++; if (o_landed !== 1'b1) begin n_fail++; $display("FAIL land_pulse: got %0b want 1", o_landed); end
        n_checks++; if (o_state !== S_LAND) begin n_fail++; $display("FAIL land_state: got %0d want %0d", o_state, S_LAND); end
        @(negedge clk); #1;
        n_checks++; if (o_landed !== 1'b0) begin n_fail++; $display("FAIL land_pulse_end: got %0b want 0", o_landed); end
        n_checks++; if (landed_pulses - lp != 1) begin n_fail++; $display("FAIL land_pulse_count: got %0d want 1", landed_pulses - lp); end
      end
    end
    n_checks++; if (!landed) begin n_fail++; $display("FAIL fall_timeout: got %0d ticks without landing want landing", k); end
  endtask

  task automatic test_land(input int x_exp);
    for (int i = 1; i <= LAND; i++) begin
      send_tick();
      if (i == LAND - 1) begin
        n_checks++; if (o_state !== S_LAND) begin n_fail++; $display("FAIL land_hold: got %0d want %0d", o_state, S_LAND); end
        n_checks++; if (o_active !== 1'b1) begin n_fail++; $display("FAIL land_active: got %0b want 1", o_active); end
      end
    end
    n_checks++; if (o_state !== S_FETCH) begin n_fail++; $display("FAIL land_to_fetch: got %0d want %0d", o_state, S_FETCH); end
    n_checks++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL land_inactive: got %0b want 0", o_active); end
    n_checks++; if (o_x !== 10'(x_exp)) begin n_fail++; $display("FAIL land_x_hold: got %0d want %0d", o_x, x_exp); end
    n_checks++; if (o_y !== 10'd418) begin n_fail++; $display("FAIL land_y_hold: got %0d want 418", o_y); end
  endtask

  task automatic test_back_to_back();
    test_fetch(517, 100, 20);
    test_hover();
    test_fall(-1, 0);
    test_land(517);
  endtask

  task automatic test_reset_mid_fall();
    int lp;
    test_fetch(77, 3, 0);
    test_hover();
    test_fall(-1, 196);
    n_checks++; if (o_y !== 10'd196) begin n_fail++; $display("FAIL midfall_y: got %0d want 196", o_y); end
    lp = landed_pulses;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (o_state !== S_FETCH) begin n_fail++; $display("FAIL async_state: got %0d want %0d", o_state, S_FETCH); end
    n_checks++; if (o_y !== 10'd0) begin n_fail++; $display("FAIL async_y: got %0d want 0", o_y); end
    n_checks++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL async_active: got %0b want 0", o_active); end
    n_checks++; if (o_landed !== 1'b0) begin n_fail++; $display("FAIL async_landed: got %0b want 0", o_landed); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (o_state !== S_FETCH) begin n_fail++; $display("FAIL post_reset_state: got %0d want %0d", o_state, S_FETCH); end
    n_checks++; if (landed_pulses != lp) begin n_fail++; $display("FAIL post_reset_landed: got %0d pulses want 0", landed_pulses - lp); end
  endtask

  initial begin
    test_reset();
    test_hover();
    test_fall(10, 0);
    test_land(300);
    test_back_to_back();
    test_reset_mid_fall();
    n_checks++; if (rden_bad != 0) begin n_fail++; $display("FAIL rden_protocol: got %0d violations want 0", rden_bad); end
    n_checks++; if (rden_pulses != 3) begin n_fail++; $display("FAIL rden_total: got %0d want 3", rden_pulses); end
    n_checks++; if (landed_pulses != 2) begin n_fail++; $display("FAIL landed_total: got %0d want 2", landed_pulses); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
